// File: rtl/decode_queue.sv
// RV32I + Zicsr instruction decoder feeding a DEPTH-entry FIFO of control bundles,
// with flush and sticky capture of the first illegal word. DECODE_MEXT_EN enables M-extension MUL decode.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [19:0]      out_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] occupancy,
  input  logic             clr_illegal,
  output logic             illegal_seen,
  output logic [31:0]      illegal_instr,
  output logic [31:0]      illegal_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {CFLOW_PCPLUS4, CFLOW_BRANCH, CFLOW_JAL, CFLOW_JALR} cflow_mode_t;
  typedef enum logic [1:0] {SYSOP_NORMAL, SYSOP_ECALL, SYSOP_EBREAK, SYSOP_MRET} sysop_mode_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z} immsrc_t;
  typedef enum logic [1:0] {SRCA_REG, SRCA_PC, SRCA_ZERO} alusrca_t;
  typedef enum logic       {SRCB_REG, SRCB_IMM} alusrcb_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_ARITH, ALUOP_BRANCH, ALUOP_MUL} aluop_t;
  typedef enum logic [1:0] {MEM_DISABLED, MEM_READ, MEM_WRITE} memaccess_t;
  typedef enum logic [1:0] {RESULT_ALU, RESULT_MEM, RESULT_PCPLUS4, RESULT_CSR} resultsrc_t;

  // Field order is the out_ctrl bit layout, MSB first.
  typedef struct packed {
    cflow_mode_t cflow;
    sysop_mode_t sysop;
    logic        fencei;
    immsrc_t     immsrc;
    alusrca_t    alusrca;
    alusrcb_t    alusrcb;
    aluop_t      aluop;
    memaccess_t  memaccess;
    resultsrc_t  resultsrc;
    logic        regwrite;
    logic        is_rtype;
    logic        is_alt;
  } ctrl_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] sys_imm;
  ctrl_t       dec;
  logic        dec_illegal;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign sys_imm = in_instr[31:20];

  // Illegal words keep their decoded datapath fields but lose every architectural side effect.
  always_comb begin
    dec = '0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.is_rtype = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_ARITH;
        case (funct7)
          7'b0000000: ;
          7'b0100000: begin
            dec.is_alt = 1'b1;
            if (funct3 != 3'b000 && funct3 != 3'b101) dec_illegal = 1'b1;
          end
          7'b0000001: begin
`ifdef DECODE_MEXT_EN
            dec.aluop = ALUOP_MUL;
`else
            dec_illegal = 1'b1;
`endif
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_ARITH;
        dec.alusrcb  = SRCB_IMM;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) dec.is_alt = 1'b1;
          else if (funct7 != 7'b0000000) dec_illegal = 1'b1;
        end
      end
      7'b0000011: begin
        dec.regwrite  = 1'b1;
        dec.alusrcb   = SRCB_IMM;
        dec.memaccess = MEM_READ;
        dec.resultsrc = RESULT_MEM;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec_illegal = 1'b1;
      end
      7'b0100011: begin
        dec.immsrc    = IMM_S;
        dec.alusrcb   = SRCB_IMM;
        dec.memaccess = MEM_WRITE;
        if (funct3 >= 3'b011) dec_illegal = 1'b1;
      end
      7'b1100011: begin
        dec.cflow  = CFLOW_BRANCH;
        dec.immsrc = IMM_B;
        dec.aluop  = ALUOP_BRANCH;
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec.regwrite = 1'b1;
        dec.immsrc   = IMM_U;
        dec.alusrcb  = SRCB_IMM;
        dec.alusrca  = opcode[5] ? SRCA_ZERO : SRCA_PC;
      end
      7'b1101111: begin
        dec.regwrite  = 1'b1;
        dec.cflow     = CFLOW_JAL;
        dec.immsrc    = IMM_J;
        dec.resultsrc = RESULT_PCPLUS4;
      end
      7'b1100111: begin
        dec.regwrite  = 1'b1;
        dec.cflow     = CFLOW_JALR;
        dec.alusrcb   = SRCB_IMM;
        dec.resultsrc = RESULT_PCPLUS4;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end
      7'b0001111: dec.fencei = (funct3 == 3'b001);
      7'b1110011: begin
        case (funct3)
          3'b000: begin
            case (sys_imm)
              12'h000: dec.sysop = SYSOP_ECALL;
              12'h001: dec.sysop = SYSOP_EBREAK;
              12'h302: dec.sysop = SYSOP_MRET;
              12'h105: ;
              default: dec_illegal = 1'b1;
            endcase
          end
          3'b100: dec_illegal = 1'b1;
          default: begin
            dec.immsrc    = IMM_Z;
            dec.resultsrc = RESULT_CSR;
            dec.regwrite  = 1'b1;
          end
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) begin
      dec.regwrite  = 1'b0;
      dec.memaccess = MEM_DISABLED;
      dec.cflow     = CFLOW_PCPLUS4;
      dec.sysop     = SYSOP_NORMAL;
      dec.fencei    = 1'b0;
    end
  end

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  ctrl_t            mem_ctrl  [DEPTH];
  logic             mem_ill   [DEPTH];
  logic             push, pop;

  assign in_ready  = (occupancy < DEPTH_C);
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head outputs read zero whenever the queue is empty, so reset and flush blank them at once.
  assign out_pc      = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr   = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_ctrl    = out_valid ? mem_ctrl[rd_ptr]  : '0;
  assign out_illegal = out_valid ? mem_ill[rd_ptr]   : 1'b0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
      mem_ctrl[wr_ptr]  <= dec;
      mem_ill[wr_ptr]   <= dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (flush) begin
      occupancy <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // A clear in the same cycle as an illegal push yields to the new capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen  <= 1'b0;
      illegal_instr <= '0;
      illegal_pc    <= '0;
    end else if (push && !flush && dec_illegal && (!illegal_seen || clr_illegal)) begin
      illegal_seen  <= 1'b1;
      illegal_instr <= in_instr;
      illegal_pc    <= in_pc;
    end else if (clr_illegal) begin
      illegal_seen  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed pushes queue expected bundles, a negedge monitor checks pops.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready, clr_illegal;
  logic        in_ready, out_valid, out_illegal, illegal_seen;
  logic [31:0] in_instr, in_pc, out_pc, out_instr, illegal_instr, illegal_pc;
  logic [19:0] out_ctrl;
  logic [2:0]  occupancy;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [19:0] ctrl;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          model_occ = 0;
  logic        model_seen = 1'b0;
  logic [31:0] model_instr = '0;
  logic [31:0] model_pc = '0;

  decode_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal), .occupancy(occupancy),
    .clr_illegal(clr_illegal), .illegal_seen(illegal_seen),
    .illegal_instr(illegal_instr), .illegal_pc(illegal_pc)
  );

  always #5 clk = ~clk;

  // Bundle layout: cflow[2] sysop[2] fencei immsrc[3] srca[2] srcb aluop[2] mem[2] result[2] regwrite rtype alt
  function automatic logic [19:0] mk(int cf, int sy, int fi, int im, int sa, int sbs,
                                     int ao, int me, int rs, int rw, int rt, int al);
    return {cf[1:0], sy[1:0], fi[0], im[2:0], sa[1:0], sbs[0], ao[1:0], me[1:0], rs[1:0],
            rw[0], rt[0], al[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus; expectations enter the scoreboard only if the bench model accepts the push.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [19:0] ectrl, input logic eill,
                               input logic rdy, input logic fl, input logic clr);
    logic acc, pp;
    exp_t e;
    in_valid = v; in_instr = instr; in_pc = pc;
    out_ready = rdy; flush = fl; clr_illegal = clr;
    acc = v && (model_occ < 4) && !fl;
    pp  = rdy && (model_occ > 0);
    if (acc) begin
      e.pc = pc; e.instr = instr; e.ctrl = ectrl; e.ill = eill;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      model_occ = 0;
      sb.delete();
    end else begin
      model_occ = model_occ + int'(acc) - int'(pp);
    end
    if (!fl && acc && eill && (!model_seen || clr)) begin
      model_seen = 1'b1; model_instr = instr; model_pc = pc;
    end else if (clr) begin
      model_seen = 1'b0;
    end
    in_valid = 1'b0; flush = 1'b0; clr_illegal = 1'b0;
    checkOutput("occupancy", 32'(occupancy), 32'(model_occ));
    checkOutput("in_ready", 32'(in_ready), 32'(model_occ < 4));
    checkOutput("out_valid", 32'(out_valid), 32'(model_occ != 0));
    checkOutput("illegal_seen", 32'(illegal_seen), 32'(model_seen));
    if (model_seen) begin
      checkOutput("illegal_instr", illegal_instr, model_instr);
      checkOutput("illegal_pc", illegal_pc, model_pc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL mon_underflow: DUT popped pc 0x%08h with no expected entry", out_pc);
      end else begin
        e = sb.pop_front();
        checkOutput("mon_pc", out_pc, e.pc);
        checkOutput("mon_instr", out_instr, e.instr);
        checkOutput("mon_ctrl", 32'(out_ctrl), 32'(e.ctrl));
        checkOutput("mon_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_illegal = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_illegal_seen", 32'(illegal_seen), 32'd0);
    checkOutput("rst_illegal_instr", illegal_instr, 32'd0);
    checkOutput("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    rst_n = 1'b1;

    // ADDI x1,x0,5 visible one edge after the push
    applyStimulus(1, 32'h00500093, 32'h100, mk(0,0,0,0,0,1,1,0,0,1,0,0), 0, 0, 0, 0);
    checkOutput("t1_out_pc", out_pc, 32'h100);
    checkOutput("t1_out_ctrl", 32'(out_ctrl), 32'(mk(0,0,0,0,0,1,1,0,0,1,0,0)));

    // Fill to DEPTH, try a fifth word, drain, then refill through a wrap with push+pop
    applyStimulus(1, 32'h002081b3, 32'h104, mk(0,0,0,0,0,0,1,0,0,1,1,0), 0, 0, 0, 0);
    applyStimulus(1, 32'h402081b3, 32'h108, mk(0,0,0,0,0,0,1,0,0,1,1,1), 0, 0, 0, 0);
    applyStimulus(1, 32'h0000a103, 32'h10c, mk(0,0,0,0,0,1,0,1,1,1,0,0), 0, 0, 0, 0);
    applyStimulus(1, 32'h123452b7, 32'h110, mk(0,0,0,3,2,1,0,0,0,1,0,0), 0, 0, 0, 0);
    checkOutput("t2_full_in_ready", 32'(in_ready), 32'd0);
    repeat (4) applyStimulus(0, 32'h0, 32'h0, 20'h0, 0, 1, 0, 0);
    applyStimulus(1, 32'h0020a223, 32'h120, mk(0,0,0,1,0,1,0,2,0,0,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h00208463, 32'h124, mk(1,0,0,2,0,0,2,0,0,0,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h010000ef, 32'h128, mk(2,0,0,4,0,0,0,0,2,1,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h00008067, 32'h12c, mk(3,0,0,0,0,1,0,0,2,1,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h00001297, 32'h130, mk(0,0,0,3,1,1,0,0,0,1,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h300110f3, 32'h134, mk(0,0,0,5,0,0,0,0,3,1,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h00000073, 32'h138, mk(0,1,0,0,0,0,0,0,0,0,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h30200073, 32'h13c, mk(0,3,0,0,0,0,0,0,0,0,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h00100073, 32'h140, mk(0,2,0,0,0,0,0,0,0,0,0,0), 0, 1, 0, 0);
    applyStimulus(1, 32'h10500073, 32'h144, 20'h0, 0, 1, 0, 0);
    applyStimulus(1, 32'h0000100f, 32'h148, mk(0,0,1,0,0,0,0,0,0,0,0,0), 0, 1, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 20'h0, 0, 1, 0, 0);

    // Illegal words and sticky capture
    applyStimulus(1, 32'h40101093, 32'h200, mk(0,0,0,0,0,1,1,0,0,0,0,0), 1, 0, 0, 0);
    applyStimulus(1, 32'h00000000, 32'h204, 20'h0, 1, 0, 0, 0);
    checkOutput("t3_keep_instr", illegal_instr, 32'h40101093);
    checkOutput("t3_keep_pc", illegal_pc, 32'h200);
    applyStimulus(1, 32'h00004073, 32'h208, 20'h0, 1, 0, 0, 1);
    checkOutput("t3_clr_capture", illegal_instr, 32'h00004073);
    applyStimulus(0, 32'h0, 32'h0, 20'h0, 0, 1, 0, 1);
    applyStimulus(1, 32'h0000b103, 32'h20c, mk(0,0,0,0,0,1,0,0,1,0,0,0), 1, 1, 0, 0);
    repeat (3) applyStimulus(0, 32'h0, 32'h0, 20'h0, 0, 1, 0, 0);
    checkOutput("t3_sb_drained", 32'(sb.size()), 32'd0);

    // Flush with a concurrent illegal push and a pop
    applyStimulus(0, 32'h0, 32'h0, 20'h0, 0, 0, 0, 1);
    applyStimulus(1, 32'h002081b3, 32'h300, mk(0,0,0,0,0,0,1,0,0,1,1,0), 0, 0, 0, 0);
    applyStimulus(1, 32'h123452b7, 32'h304, mk(0,0,0,3,2,1,0,0,0,1,0,0), 0, 0, 0, 0);
    applyStimulus(1, 32'h10500073, 32'h308, 20'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h00000000, 32'h400, 20'h0, 1, 1, 1, 0);
    checkOutput("t4_out_pc", out_pc, 32'h0);
    checkOutput("t4_no_capture", 32'(illegal_seen), 32'd0);

    // MUL with and without the M extension
`ifdef DECODE_MEXT_EN
    applyStimulus(1, 32'h02208033, 32'h500, mk(0,0,0,0,0,0,3,0,0,1,1,0), 0, 0, 0, 0);
    checkOutput("t5_mul_illegal", 32'(out_illegal), 32'd0);
`else
    applyStimulus(1, 32'h02208033, 32'h500, mk(0,0,0,0,0,0,1,0,0,0,1,0), 1, 0, 0, 0);
    checkOutput("t5_mul_illegal", 32'(out_illegal), 32'd1);
    checkOutput("t5_mul_seen", 32'(illegal_seen), 32'd1);
`endif
    checkOutput("t5_mul_ctrl", 32'(out_ctrl),
`ifdef DECODE_MEXT_EN
                32'(mk(0,0,0,0,0,0,3,0,0,1,1,0)));
`else
                32'(mk(0,0,0,0,0,0,1,0,0,0,1,0)));
`endif

    // Asynchronous reset mid-stream
    applyStimulus(1, 32'h00000000, 32'h504, 20'h0, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_occupancy", 32'(occupancy), 32'd0);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_out_pc", out_pc, 32'h0);
    checkOutput("t6_out_instr", out_instr, 32'h0);
    checkOutput("t6_out_ctrl", 32'(out_ctrl), 32'd0);
    checkOutput("t6_out_illegal", 32'(out_illegal), 32'd0);
    checkOutput("t6_illegal_seen", 32'(illegal_seen), 32'd0);
    checkOutput("t6_illegal_instr", illegal_instr, 32'h0);
    checkOutput("t6_illegal_pc", illegal_pc, 32'h0);
    sb.delete();
    model_occ = 0;
    model_seen = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 32'h0, 32'h0, 20'h0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-instruction combinational main decoder.
- Decodes RV32I + Zicsr (+ M, optional) instruction words at the fetch/decode boundary and buffers the decoded control bundles in a DEPTH-entry FIFO.
- Valid/ready handshakes on both sides.
- Adds stricter field legality checks, pipeline flush, and sticky capture of the first illegal instruction for the trap unit.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  drop all buffered entries
in_valid  in  1  instruction word presented
in_ready  out  1  queue can accept
in_instr  in  32  instruction word
in_pc  in  32  PC of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head
out_pc  out  32  head PC
out_instr  out  32  head raw word
out_ctrl  out  packed bundle  cflow_mode_t, sysop_mode_t, fencei, immsrc_t, alusrca_t, alusrcb_t, aluop_t, memaccess_t, resultsrc_t, regwrite, is_rtype, is_alt
out_illegal  out  1  head entry is illegal
occupancy  out  CNT_W  entries held
clr_illegal  in  1  clear sticky capture
illegal_seen  out  1  sticky flag
illegal_instr  out  32  first illegal word captured
illegal_pc  out  32  PC of that word

Behaviour:
- Reset (async, rst_n=0):
  - occupancy=0, out_valid=0, pointers=0.
  - illegal_seen=0, illegal_instr=0, illegal_pc=0.
  - out_ctrl/out_pc/out_instr=0.
- Push and pop:
  - Push when in_valid && in_ready.
  - in_ready = (occupancy < DEPTH); registered-state only, no combinational path from out_ready.
  - Decode is combinational on in_instr; the bundle is written to the FIFO at the push edge.
  - Latency: a push at edge N gives out_valid=1 after edge N when the queue was empty.
  - Pop when out_valid && out_ready. Simultaneous push+pop keeps occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - out_* show the head entry; they are stable while out_valid && !out_ready.
- Decode table (base):
  - OP: is_rtype=1, regwrite=1. funct7 0000000 gives ARITH; 0100000 gives ARITH with is_alt=1 (legal only for funct3 000/101); 0000001 gives MUL (see feature).
  - OP-IMM: ARITH with SRCB_IMM. funct3 001 requires funct7=0000000. funct3 101 requires funct7 0000000 or 0100000 (is_alt=1).
  - LOAD: MEM_READ, RESULT_MEM. funct3 011/110/111 is illegal.
  - STORE: MEM_WRITE, IMM_S. funct3 >= 011 is illegal.
  - BRANCH: CFLOW_BRANCH, IMM_B. funct3 010/011 is illegal.
  - LUI uses SRCA_ZERO; AUIPC uses SRCA_PC.
  - JAL/JALR write RESULT_PCPLUS4. JALR funct3 != 000 is illegal.
  - MISC-MEM: fencei when funct3=001.
  - SYSTEM, funct3=000: imm 000 gives ECALL, 001 EBREAK, 302 MRET, 105 WFI (nop); any other imm is illegal.
  - SYSTEM, funct3=100 is illegal. Other funct3 values are CSR ops: IMM_Z, RESULT_CSR, regwrite=1.
  - in_instr[1:0] != 11 is illegal. Unknown opcode is illegal.
- Illegal entries:
  - Stored with out_illegal=1.
  - Forced regwrite=0, MEM_DISABLED, CFLOW_PCPLUS4, SYSOP_NORMAL, fencei=0.
- Sticky capture:
  - When an illegal entry is pushed and illegal_seen=0: illegal_seen=1, and illegal_instr/illegal_pc are latched.
  - Later illegal pushes do not overwrite.
  - clr_illegal clears the flag. If clr_illegal coincides with an illegal push, the new push is captured (flag stays 1, new values).
- Flush:
  - Takes priority. At the next edge occupancy=0 and out_valid=0.
  - A same-cycle push and pop are discarded.
  - Sticky capture is unaffected, except that a push in the flush cycle is not captured.

Optional Feature:
- Macro: DECODE_MEXT_EN.
- Defined: OP with funct7=0000001 decodes ALUOP_MUL, regwrite=1, is_alt=0.
- Undefined: funct7=0000001 on OP is illegal, and no MUL encoding is ever produced.

Test Plan:
1. Reset, then push ADDI x1,x0,5 (0x00500093, pc 0x100) with out_ready=0 -> one edge later out_valid=1, out_pc=0x100, aluop=ARITH, alusrc_b=SRCB_IMM, regwrite=1, occupancy=1.
2. Push DEPTH=4 words with out_ready=0 -> in_ready=0 when occupancy=4. A fifth in_valid is not accepted. Draining returns the words in order, and pointers wrap correctly on refill.
3. Push SLLI with funct7=0100000 (0x40101093, pc 0x200), then 0x00000000 (pc 0x204) -> both have out_illegal=1 and regwrite=0. illegal_instr=0x40101093, illegal_pc=0x200 (the second is not captured). clr_illegal in the same cycle as an illegal push -> the new value is captured.
4. Occupancy=3, assert flush together with in_valid and out_ready -> next edge occupancy=0, out_valid=0, nothing captured.
5. Push MUL (0x02208033) -> with DECODE_MEXT_EN: aluop=MUL, out_illegal=0. Without the macro: out_illegal=1, illegal_seen=1.
6. Drop rst_n asynchronously mid-stream with occupancy=2 and illegal_seen=1 -> all outputs are 0 immediately, without waiting for a clock edge.
